// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one WIDTH-bit adder among NREQ requesters.
// Latency: a transfer in cycle c presents its registered result in cycle c+2; one op per cycle.
// Backpressure: res_ready low stalls S2, then S1; grant drops only once both stages are full.
module adder_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 32,
   parameter int TAG_W = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] a_flat,
   input  logic [NREQ*WIDTH-1:0] b_flat,
   output logic [NREQ-1:0]       grant,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [WIDTH-1:0]      res_sum,
   output logic                  res_pov,
   output logic                  res_nov,
   output logic [TAG_W-1:0]      res_tag
);

   // Reset value of the last-winner pointer, so requester 0 is searched first.
   localparam logic [TAG_W-1:0] LAST_IDX = TAG_W'(NREQ - 1);

   // Round-robin state
   logic [TAG_W-1:0] ptr;
   logic [TAG_W-1:0] win_idx;
   logic [TAG_W-1:0] cand_idx;
   logic             found;
   int               cand;

   // Stage 1: registered operands of the winner
   logic             v1;
   logic [WIDTH-1:0] a1;
   logic [WIDTH-1:0] b1;
   logic [TAG_W-1:0] tag1;

   // Winner operand mux and adder
   logic [WIDTH-1:0] a_win;
   logic [WIDTH-1:0] b_win;
   logic [WIDTH-1:0] sum1;
   logic             pov1;
   logic             nov1;

   // Flow control
   logic             adv1;
   logic             adv2;
   logic             xfer;

   // S2 can accept when empty or draining; S1 can accept when empty or moving into S2.
   assign adv2 = !res_valid || res_ready;
   assign adv1 = !v1 || adv2;

   // Search upward from the slot after the last winner, wrapping once around all requesters.
   always_comb begin
      found    = 1'b0;
      win_idx  = '0;
      cand     = 0;
      cand_idx = '0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = int'(ptr) + k;
         if (cand >= NREQ) begin
            cand = cand - NREQ;
         end
         cand_idx = cand[TAG_W-1:0];
         if (!found && req[cand_idx]) begin
            found   = 1'b1;
            win_idx = cand_idx;
         end
      end
   end

   // One-hot grant, suppressed while reset is high or S1 cannot take a new operation.
   always_comb begin
      grant = '0;
      if (adv1 && !rst && found) begin
         grant[win_idx] = 1'b1;
      end
   end

   // A grant is only ever given to a requesting slot, so any grant bit is a transfer.
   assign xfer = |grant;

   // Pick the winner's operand pair out of the flattened buses.
   always_comb begin
      a_win = '0;
      b_win = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (win_idx == TAG_W'(i)) begin
            a_win = a_flat[i*WIDTH +: WIDTH];
            b_win = b_flat[i*WIDTH +: WIDTH];
         end
      end
   end

   // Pointer remembers the last winner; it moves only on an actual transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= LAST_IDX;
      end else if (xfer) begin
         ptr <= win_idx;
      end
   end

   // Stage 1 register: capture the winner, or empty out when advancing with nothing new.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1   <= 1'b0;
         a1   <= '0;
         b1   <= '0;
         tag1 <= '0;
      end else if (adv1) begin
         v1 <= xfer;
         if (xfer) begin
            a1   <= a_win;
            b1   <= b_win;
            tag1 <= win_idx;
         end
      end
   end

   // Shared adder with signed-overflow detection from operand and sum sign bits.
   assign sum1 = a1 + b1;
   assign pov1 = !a1[WIDTH-1] && !b1[WIDTH-1] &&  sum1[WIDTH-1];
   assign nov1 =  a1[WIDTH-1] &&  b1[WIDTH-1] && !sum1[WIDTH-1];

   // Result register: payload loads only with a valid op so it holds across bubbles and stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_pov   <= 1'b0;
         res_nov   <= 1'b0;
         res_tag   <= '0;
      end else if (adv2) begin
         res_valid <= v1;
         if (v1) begin
            res_sum <= sum1;
            res_pov <= pov1;
            res_nov <= nov1;
            res_tag <= tag1;
         end
      end
   end

   // Structural invariants: at most one grant, only to requesters, exclusive overflow flags.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert ($onehot0(grant));
         assert ((grant & ~req) == '0);
         assert (!(res_pov && res_nov));
      end
   end

   // A stalled result must stay valid and unchanged until it is accepted.
   assert property (@(posedge clk) disable iff (rst)
      (res_valid && !res_ready) |=> (res_valid && $stable(res_sum) && $stable(res_tag)
                                     && $stable(res_pov) && $stable(res_nov)));

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: directed vectors with literal expectations plus a per-cycle
// reference model built from in-flight capacity, round-robin order and signed arithmetic.
module tb_adder_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 32;
   localparam int TAG_W = 2;

   logic                  clk;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] a_flat;
   logic [NREQ*WIDTH-1:0] b_flat;
   logic [NREQ-1:0]       grant;
   logic                  res_valid;
   logic                  res_ready;
   logic [WIDTH-1:0]      res_sum;
   logic                  res_pov;
   logic                  res_nov;
   logic [TAG_W-1:0]      res_tag;

   int errors = 0;
   int checks = 0;

   adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .a_flat    (a_flat),
      .b_flat    (b_flat),
      .grant     (grant),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_pov   (res_pov),
      .res_nov   (res_nov),
      .res_tag   (res_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      int          tag;
      int          vis;   // first cycle this op may be shown as the result
   } op_t;

   op_t         inflight[$];
   int          mptr = NREQ - 1;
   int          cyc  = 0;
   int          win;
   int          idx;
   logic [3:0]  exp_grant;
   logic        exp_valid;
   logic [31:0] exp_sum;
   longint      wide;
   op_t         nop;

   // Once per cycle, away from the edge: compare DUT against the model, then advance the model.
   always @(negedge clk) begin
      win = -1;
      // At most two ops can be in flight; a full pipeline only takes a new op while draining.
      if (!rst && (inflight.size() < 2 || res_ready)) begin
         for (int k = 1; k <= NREQ; k++) begin
            idx = (mptr + k) % NREQ;
            if (win < 0 && req[idx]) win = idx;
         end
      end
      exp_grant = (win >= 0) ? (4'b0001 << win) : 4'b0000;
      check("model_grant", {60'd0, grant}, {60'd0, exp_grant});

      exp_valid = (inflight.size() > 0) && (inflight[0].vis <= cyc);
      check("model_valid", {63'd0, res_valid}, {63'd0, exp_valid});
      if (exp_valid && res_valid) begin
         exp_sum = inflight[0].a + inflight[0].b;
         wide    = longint'($signed(inflight[0].a)) + longint'($signed(inflight[0].b));
         check("model_sum", {32'd0, res_sum}, {32'd0, exp_sum});
         check("model_pov", {63'd0, res_pov}, {63'd0, wide > 64'sd2147483647});
         check("model_nov", {63'd0, res_nov}, {63'd0, wide < -64'sd2147483648});
         check("model_tag", {62'd0, res_tag}, 64'(inflight[0].tag));
      end

      if (rst) begin
         inflight.delete();
         mptr = NREQ - 1;
      end else begin
         if (exp_valid && res_ready) void'(inflight.pop_front());
         if (win >= 0) begin
            nop.a   = a_flat[win*WIDTH +: WIDTH];
            nop.b   = b_flat[win*WIDTH +: WIDTH];
            nop.tag = win;
            nop.vis = cyc + 2;
            inflight.push_back(nop);
            mptr = win;
         end
      end
      cyc++;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
      a_flat[i*WIDTH +: WIDTH] = a;
      b_flat[i*WIDTH +: WIDTH] = b;
   endtask

   // Issue one op from requester r alone and check its result two cycles later.
   task automatic one_op(input string name, input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] s, input logic pov, input logic nov);
      logic [3:0] g;
      g = 4'b0001 << r;
      tick();
      req = g;
      set_op(r, a, b);
      #2 check({name, "_grant"}, {60'd0, grant}, {60'd0, g});
      tick();
      req = '0;
      tick();
      #2;
      check({name, "_valid"}, {63'd0, res_valid}, 64'd1);
      check({name, "_sum"},   {32'd0, res_sum},   {32'd0, s});
      check({name, "_pov"},   {63'd0, res_pov},   {63'd0, pov});
      check({name, "_nov"},   {63'd0, res_nov},   {63'd0, nov});
      check({name, "_tag"},   {62'd0, res_tag},   64'(r));
   endtask

   logic [3:0] rr_grant [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};
   int         rr_tag   [5] = '{0, 1, 2, 3, 0};
   int         bp_tag   [4] = '{0, 1, 2, 3};

   initial begin
      rst       = 1'b1;
      req       = 4'b1111;
      a_flat    = '0;
      b_flat    = '0;
      res_ready = 1'b1;

      // Reset: grant gated even with every requester asking.
      tick();
      tick();
      #2;
      check("rst_grant", {60'd0, grant},     64'd0);
      check("rst_valid", {63'd0, res_valid}, 64'd0);
      check("rst_sum",   {32'd0, res_sum},   64'd0);
      check("rst_tag",   {62'd0, res_tag},   64'd0);

      // Single request from requester 0.
      tick();
      rst = 1'b0;
      req = 4'b0001;
      set_op(0, 32'd5, 32'd7);
      #2 check("single_grant", {60'd0, grant}, 64'd1);
      tick();
      req = '0;
      tick();
      #2;
      check("single_valid", {63'd0, res_valid}, 64'd1);
      check("single_sum",   {32'd0, res_sum},   64'd12);
      check("single_tag",   {62'd0, res_tag},   64'd0);
      check("single_flags", {62'd0, res_pov, res_nov}, 64'd0);

      // Overflow and signed cases; lone requesters win whatever the pointer.
      one_op("povf", 1, 32'h7DDDDDDD, 32'h7DDDDDDD, 32'hFBBBBBBA, 1'b1, 1'b0);
      one_op("novf", 2, 32'h80000001, 32'h80000001, 32'h00000002, 1'b0, 1'b1);
      one_op("negneg", 0, 32'hFFFFFFFB, 32'hFFFFFFF9, 32'hFFFFFFF4, 1'b0, 1'b0);
      one_op("posneg", 3, 32'h00000008, 32'hFFFFFFF7, 32'hFFFFFFFF, 1'b0, 1'b0);

      // Round-robin with all four requesting continuously.
      tick();
      rst = 1'b1;
      req = '0;
      for (int i = 0; i < NREQ; i++) set_op(i, 32'(1000 * (i + 1)), 32'(i + 1));
      tick();
      rst = 1'b0;
      req = 4'b1111;
      for (int k = 0; k < 7; k++) begin
         #2;
         check("rr_grant", {60'd0, grant}, {60'd0, rr_grant[k]});
         if (k >= 2 && k < 7) begin
            check("rr_valid", {63'd0, res_valid}, 64'd1);
            if (k - 2 < 5) check("rr_tag", {62'd0, res_tag}, 64'(rr_tag[k-2]));
         end
         tick();
      end
      req = '0;
      repeat (4) tick();

      // Backpressure: two ops fill the pipe, then grant stops and the result freezes.
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      res_ready = 1'b0;
      req       = 4'b1111;
      #2 check("bp_grant0", {60'd0, grant}, 64'd1);
      tick();
      #2 check("bp_grant1", {60'd0, grant}, 64'd2);
      tick();
      #2;
      check("bp_grant_stall", {60'd0, grant},   64'd0);
      check("bp_sum_stall",   {32'd0, res_sum}, 64'd1001);
      check("bp_tag_stall",   {62'd0, res_tag}, 64'd0);
      tick();
      #2;
      check("bp_grant_hold", {60'd0, grant},   64'd0);
      check("bp_sum_hold",   {32'd0, res_sum}, 64'd1001);
      check("bp_tag_hold",   {62'd0, res_tag}, 64'd0);
      tick();
      res_ready = 1'b1;
      #2 check("bp_grant_drain", {60'd0, grant}, 64'd4);
      check("bp_tag_d0", {62'd0, res_tag}, 64'(bp_tag[0]));
      tick();
      req = 4'b1000;
      #2 check("bp_grant_last", {60'd0, grant}, 64'd8);
      check("bp_tag_d1", {62'd0, res_tag}, 64'(bp_tag[1]));
      check("bp_sum_d1", {32'd0, res_sum}, 64'd2002);
      tick();
      req = '0;
      #2 check("bp_tag_d2", {62'd0, res_tag}, 64'(bp_tag[2]));
      tick();
      #2 check("bp_tag_d3", {62'd0, res_tag}, 64'(bp_tag[3]));
      check("bp_sum_d3", {32'd0, res_sum}, 64'd4004);
      tick();
      #2 check("bp_empty", {63'd0, res_valid}, 64'd0);

      // Reset with both stages full: everything in flight is dropped.
      tick();
      res_ready = 1'b0;
      req       = 4'b1111;
      tick();
      tick();
      tick();
      rst = 1'b1;
      #2 check("mid_rst_grant", {60'd0, grant}, 64'd0);
      tick();
      rst       = 1'b0;
      res_ready = 1'b1;
      #2;
      check("mid_valid", {63'd0, res_valid}, 64'd0);
      check("mid_sum",   {32'd0, res_sum},   64'd0);
      check("mid_tag",   {62'd0, res_tag},   64'd0);
      check("mid_flags", {62'd0, res_pov, res_nov}, 64'd0);
      check("mid_grant", {60'd0, grant},     64'd1);
      tick();
      tick();
      req = '0;
      repeat (5) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
